// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver for the game-side RxD pin.
//
// Deserialises bytes from the controller-side transmitter (paddle commands
// 0x01 = up, 0x80 = down, or a raw 8-bit paddle position). Each good byte is
// presented on `data` together with a single-cycle `valid` strobe.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous, active-high reset
//   RxD        in   asynchronous serial line, idles high
//   data       out  [7:0] last correctly framed byte (LSB received first)
//   valid      out  one-cycle pulse when data updates
//   frame_err  out  one-cycle pulse when the stop bit samples low
//   busy       out  high from start-bit detection until return to idle
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every sample point takes three samples
//                        of the synchronised line (target-1, target, target+1)
//                        and uses the majority value; single-cycle glitches at
//                        the sample point are rejected. The port list is the
//                        same in both builds.

module uart_rx #(
  parameter int unsigned CLK_FREQ  = 65_000_000,
  parameter int unsigned BAUD_RATE = 9_600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned BIT_TICKS  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;

  localparam logic [12:0] BIT_LAST  = 13'(BIT_TICKS - 1);
  localparam logic [12:0] HALF_LAST = 13'(HALF_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  // Two-flop synchroniser; idle level is high so both flops reset to 1.
  logic rx_meta_q;
  logic rx_s_q;

  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;

  // Sample-point decision shared by START, DATA and STOP.
  logic [12:0] target;      // nominal sample count for the current state
  logic        fire;        // this cycle completes the sample point
  logic        sval;        // value decided at the sample point
  logic [12:0] restart;     // counter value for the next bit period

  always_comb begin
    target = (state_q == S_START) ? HALF_LAST : BIT_LAST;
  end

`ifdef UART_RX_MAJORITY_EN
  // Samples taken at target-1 and target; the third sample is the live rx_s
  // at target+1, where the decision and any state transition happen.
  logic [1:0] smp_q, smp_d;

  always_comb begin
    smp_d = smp_q;
    if (cnt_q == target - 13'd1) smp_d[1] = rx_s_q;
    if (cnt_q == target)         smp_d[0] = rx_s_q;
    fire    = (cnt_q == target + 13'd1);
    sval    = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s_q) | (smp_q[0] & rx_s_q);
    // The decision lands one cycle after the nominal centre, so the next bit
    // period starts already one tick in; sample centres stay where they were.
    restart = 13'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) smp_q <= '0;
    else     smp_q <= smp_d;
  end
`else
  always_comb begin
    fire    = (cnt_q == target);
    sval    = rx_s_q;
    restart = '0;
  end
`endif

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 13'd1;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        if (fire) begin
          if (!sval) begin
            state_d = S_DATA;
            idx_d   = '0;
            cnt_d   = restart;
          end else begin
            // False start: line went back high before mid-start-bit.
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end

      S_DATA: begin
        if (fire) begin
          // LSB arrives first: shift right with the new bit entering the MSB.
          shift_d = {sval, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          cnt_d   = restart;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end

      S_STOP: begin
        if (fire) begin
          cnt_d = '0;
          if (sval) begin
            // Back to idle mid-stop-bit so an immediately following start
            // edge is caught.
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // A line held low must not be mistaken for a new start bit.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= RxD;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx - self-checking bench for uart_rx.
// Runs the receiver at 16 clocks per bit so every scenario stays short.
// A queue of expected receive events (good byte or framing error, with the
// cycle the frame started) is filled by the stimulus tasks and drained by a
// per-cycle compare process that also checks data holding, reset values,
// strobe exclusivity and event latency.

module tb_uart_rx;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned BIT      = CLK_FREQ / BAUD;   // 16
  localparam int unsigned HALF     = BIT / 2;           // 8
  // Event should appear about mid-stop-bit plus synchroniser delay.
  localparam int unsigned LAT_NOM  = HALF + 9 * BIT + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .RxD      (RxD),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_seen = 1'b0;
  always @(posedge clk) rst_seen <= rst;

  typedef struct {
    bit          is_err;
    logic [7:0]  d;
    int unsigned t0;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         ev;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  model_data = 8'h00;
  int unsigned last_valid_cyc = 0;
  int unsigned prev_valid_cyc = 0;
  int unsigned dt;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_seen) begin
      model_data = 8'h00;
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_data", {24'd0, data}, 32'd0);
    end else begin
      chk("strobe_excl", {31'd0, valid & frame_err}, 32'd0);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event valid=%0b frame_err=%0b required=none (cycle %0d)",
                   valid, frame_err, cyc);
        end else begin
          ev = exp_q.pop_front();
          chk("event_kind", {31'd0, frame_err}, {31'd0, ev.is_err});
          dt = cyc - ev.t0;
          checks++;
          if (dt < LAT_NOM - 1 || dt > LAT_NOM + 3) begin
            errors++;
            $display("FAIL event_latency got=%0d required=%0d..%0d", dt, LAT_NOM - 1, LAT_NOM + 3);
          end
          // Idle is re-entered on a good stop bit; a bad one parks in break.
          chk("busy_at_event", {31'd0, busy}, {31'd0, ev.is_err});
          if (valid) begin
            model_data     = ev.d;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
          end
        end
      end
      chk("data_hold", {24'd0, data}, {24'd0, model_data});
    end
  end

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    RxD = 1'b1;
    wait_cyc(n);
  endtask

  // Drive one frame. glitch marks bits that get a one-cycle high pulse at
  // their centre; rst_bit < 8 pulses reset during that bit (no event then).
  task automatic send(input logic [7:0] b, input logic stop_bit,
                      input logic [7:0] glitch, input int unsigned rst_bit,
                      input logic [7:0] exp_d);
    ev_t e;
    e.is_err = !stop_bit;
    e.d      = exp_d;
    e.t0     = cyc;
    if (rst_bit >= 8) exp_q.push_back(e);
    RxD = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      if (glitch[i]) begin
        wait_cyc(HALF);
        RxD = 1'b1;
        wait_cyc(1);
        RxD = b[i];
        wait_cyc(BIT - HALF - 1);
      end else if (rst_bit == i) begin
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(BIT - 3);
      end else begin
        wait_cyc(BIT);
      end
    end
    RxD = stop_bit;
    wait_cyc(BIT);
  endtask

  initial begin
    @(posedge clk);
    #1;
    wait_cyc(3);
    rst = 1'b0;
    idle(100);

    // Single frame.
    send(8'h01, 1'b1, 8'h00, 8, 8'h01);
    idle(2 * BIT);
    chk("data_01", {24'd0, data}, 32'h01);
    chk("busy_after_01", {31'd0, busy}, 32'd0);

    // Back-to-back frames, no idle gap.
    send(8'h80, 1'b1, 8'h00, 8, 8'h80);
    send(8'hA5, 1'b1, 8'h00, 8, 8'hA5);
    idle(2 * BIT);
    chk("data_A5", {24'd0, data}, 32'hA5);
    chk("b2b_gap", last_valid_cyc - prev_valid_cyc, 10 * BIT);

    // False start: low for less than half a bit.
    RxD = 1'b0;
    wait_cyc(4);
    chk("busy_false_start", {31'd0, busy}, 32'd1);
    RxD = 1'b1;
    wait_cyc(HALF + 2);
    chk("busy_after_false_start", {31'd0, busy}, 32'd0);
    idle(2 * BIT);

    // Stop bit low, line held low, then a good frame.
    send(8'h3C, 1'b0, 8'h00, 8, 8'h00);
    RxD = 1'b0;
    wait_cyc(300);
    chk("busy_in_break", {31'd0, busy}, 32'd1);
    chk("data_kept_ferr", {24'd0, data}, 32'hA5);
    idle(3 * BIT);
    chk("busy_after_break", {31'd0, busy}, 32'd0);
    send(8'h55, 1'b1, 8'h00, 8, 8'h55);
    idle(2 * BIT);
    chk("data_55", {24'd0, data}, 32'h55);

    // Reset during data bit 4 of 0xFF, then a good frame.
    send(8'hFF, 1'b1, 8'h00, 4, 8'h00);
    idle(2 * BIT);
    chk("data_after_rst", {24'd0, data}, 32'h00);
    chk("busy_after_rst", {31'd0, busy}, 32'd0);
    send(8'h12, 1'b1, 8'h00, 8, 8'h12);
    idle(2 * BIT);
    chk("data_12", {24'd0, data}, 32'h12);

    // 0x00 with one-cycle high pulses at the centres of bits 2 and 5.
`ifdef UART_RX_MAJORITY_EN
    send(8'h00, 1'b1, 8'h24, 8, 8'h00);
    idle(2 * BIT);
    chk("data_glitch", {24'd0, data}, 32'h00);
`else
    send(8'h00, 1'b1, 8'h24, 8, 8'h24);
    idle(2 * BIT);
    chk("data_glitch", {24'd0, data}, 32'h24);
`endif

    idle(3 * BIT);
    chk("pending_events", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
